branch_predictor_update_unit: RTL and testbench



---
 rtl/branch_predictor_update_unit_if.sv | 38 +++
 rtl/branch_predictor_update_unit.sv | 135 +++++++++++++
 tb/tb_branch_predictor_update_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_update_unit_if.sv
// Update, fetch-lookup and predictor-RAM signals of the branch predictor update unit.
// The slave modport is the unit; the master modport is execute/fetch/RAM around it.
interface branch_predictor_update_unit_if #(
    parameter int unsigned C_DEPTH     = 512,
    parameter int unsigned C_TAG_WIDTH = 12
);
    localparam int unsigned IW = $clog2(C_DEPTH);
    localparam int unsigned DW = C_TAG_WIDTH + 3;

    logic                   upd_valid;
    logic                   upd_ready;
    logic [IW-1:0]          upd_index;
    logic [C_TAG_WIDTH-1:0] upd_tag;
    logic                   upd_taken;
    logic                   fetch_read_en;
    logic [IW-1:0]          fetch_read_addr;
    logic                   ram_read_en;
    logic [IW-1:0]          ram_read_addr;
    logic [DW-1:0]          ram_read_data;
    logic                   ram_write_en;
    logic [IW-1:0]          ram_write_addr;
    logic [DW-1:0]          ram_write_data;
    logic                   busy;

    modport slave (
        input  upd_valid, upd_index, upd_tag, upd_taken,
        input  fetch_read_en, fetch_read_addr, ram_read_data,
        output upd_ready, ram_read_en, ram_read_addr,
        output ram_write_en, ram_write_addr, ram_write_data, busy
    );

    modport master (
        output upd_valid, upd_index, upd_tag, upd_taken,
        output fetch_read_en, fetch_read_addr, ram_read_data,
        input  upd_ready, ram_read_en, ram_read_addr,
        input  ram_write_en, ram_write_addr, ram_write_data, busy
    );
endinterface

// File: rtl/branch_predictor_update_unit.sv
// Buffers resolved-branch outcomes and applies them to the predictor RAM as
// read-modify-write 2-bit counter updates, yielding the read port to fetch.
module branch_predictor_update_unit #(
    parameter int unsigned C_DEPTH      = 512,
    parameter int unsigned C_TAG_WIDTH  = 12,
    parameter int unsigned C_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    branch_predictor_update_unit_if.slave bus
);
    localparam int unsigned IW = $clog2(C_DEPTH);
    localparam int unsigned PW = $clog2(C_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [IW-1:0]          index;
        logic [C_TAG_WIDTH-1:0] tag;
        logic                   taken;
    } upd_t;

    typedef struct packed {
        logic                   valid;
        logic [C_TAG_WIDTH-1:0] tag;
        logic [1:0]             ctr;
    } entry_t;

    upd_t                   fifo_mem [C_FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic                   m_valid_q, m_valid_d;
    logic [IW-1:0]          m_index_q, m_index_d;
    logic [C_TAG_WIDTH-1:0] m_tag_q, m_tag_d;
    logic                   m_taken_q, m_taken_d;

    logic                   fwd_hit_q, fwd_hit_d;
    logic [IW-1:0]          fwd_index_q, fwd_index_d;
    entry_t                 fwd_data_q, fwd_data_d;

    logic                   upd_ready_c;
    logic                   push_c;
    logic                   issue_c;
    upd_t                   head_c;
    upd_t                   push_entry_c;
    entry_t                 old_entry_c;
    entry_t                 new_entry_c;

    // upd_ready depends only on the registered count, so a same-cycle pop never raises it
    assign upd_ready_c  = (count_q != CW'(C_FIFO_DEPTH));
    assign push_c       = bus.upd_valid && upd_ready_c;
    assign issue_c      = (count_q != '0) && !bus.fetch_read_en;
    assign head_c       = fifo_mem[rd_ptr_q];
    assign push_entry_c = '{index: bus.upd_index, tag: bus.upd_tag, taken: bus.upd_taken};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c)  wr_ptr_d = wr_ptr_q + PW'(1);
        if (issue_c) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push_c) - CW'(issue_c);
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr_q] <= push_entry_c;
    end

    // The RAM returns pre-write data on a same-address read/write, so a back-to-back
    // update to the index just written takes the freshly computed entry instead
    always_comb begin
        old_entry_c = entry_t'(bus.ram_read_data);
        if (fwd_hit_q && (fwd_index_q == m_index_q)) old_entry_c = fwd_data_q;

        new_entry_c = '{valid: 1'b1, tag: m_tag_q, ctr: (m_taken_q ? 2'b10 : 2'b01)};
        if (old_entry_c.valid && (old_entry_c.tag == m_tag_q)) begin
            new_entry_c.ctr = old_entry_c.ctr;
            if (m_taken_q && (old_entry_c.ctr != 2'b11))       new_entry_c.ctr = old_entry_c.ctr + 2'd1;
            else if (!m_taken_q && (old_entry_c.ctr != 2'b00)) new_entry_c.ctr = old_entry_c.ctr - 2'd1;
        end
    end

    always_comb begin
        m_valid_d   = issue_c;
        m_index_d   = m_index_q;
        m_tag_d     = m_tag_q;
        m_taken_d   = m_taken_q;
        fwd_hit_d   = issue_c && m_valid_q && (head_c.index == m_index_q);
        fwd_index_d = fwd_index_q;
        fwd_data_d  = fwd_data_q;
        if (issue_c) begin
            m_index_d = head_c.index;
            m_tag_d   = head_c.tag;
            m_taken_d = head_c.taken;
        end
        if (m_valid_q) begin
            fwd_index_d = m_index_q;
            fwd_data_d  = new_entry_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            m_valid_q   <= 1'b0;
            m_index_q   <= '0;
            m_tag_q     <= '0;
            m_taken_q   <= 1'b0;
            fwd_hit_q   <= 1'b0;
            fwd_index_q <= '0;
            fwd_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            m_valid_q   <= m_valid_d;
            m_index_q   <= m_index_d;
            m_tag_q     <= m_tag_d;
            m_taken_q   <= m_taken_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_index_q <= fwd_index_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign bus.upd_ready      = upd_ready_c;
    assign bus.ram_read_en    = bus.fetch_read_en | issue_c;
    assign bus.ram_read_addr  = bus.fetch_read_en ? bus.fetch_read_addr : head_c.index;
    assign bus.ram_write_en   = m_valid_q;
    assign bus.ram_write_addr = m_index_q;
    assign bus.ram_write_data = new_entry_c;
    assign bus.busy           = (count_q != '0) || m_valid_q;
endmodule

// File: tb/tb_branch_predictor_update_unit.sv
// Directed bench for branch_predictor_update_unit with a behavioural
// read-before-write predictor RAM and per-cycle read/write logging.
module tb_branch_predictor_update_unit;
    localparam int unsigned IW = 9;
    localparam int unsigned TW = 12;
    localparam int unsigned DW = TW + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_update_unit_if #(.C_DEPTH(512), .C_TAG_WIDTH(TW)) bus ();

    branch_predictor_update_unit #(
        .C_DEPTH(512), .C_TAG_WIDTH(TW), .C_FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered-read RAM returning old data on same-address read/write
    logic [DW-1:0] mem [512];
    logic          pre_en;
    logic [IW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (bus.ram_read_en)  bus.ram_read_data <= mem[bus.ram_read_addr];
        if (bus.ram_write_en) mem[bus.ram_write_addr] <= bus.ram_write_data;
        if (pre_en)           mem[pre_addr] <= pre_data;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int            rd_addr_q [$];
    int            rd_cyc_q  [$];
    int            wr_addr_q [$];
    int            wr_cyc_q  [$];
    logic [DW-1:0] wr_data_q [$];
    int            push_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven just after a negedge; outputs are logged 1 time unit later
    task automatic step();
        #1;
        if (bus.ram_read_en) begin
            rd_addr_q.push_back(int'(bus.ram_read_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (bus.ram_write_en) begin
            wr_addr_q.push_back(int'(bus.ram_write_addr));
            wr_data_q.push_back(bus.ram_write_data);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.upd_valid && bus.upd_ready) push_cyc_q.push_back(cyc);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete();
        wr_addr_q.delete(); wr_cyc_q.delete(); wr_data_q.delete();
        push_cyc_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic preload(input int addr, input logic [DW-1:0] data);
        pre_en   = 1'b1;
        pre_addr = IW'(addr);
        pre_data = data;
        step();
        pre_en   = 1'b0;
    endtask

    task automatic drive_upd(input logic v, input int idx, input int tag, input logic tk);
        bus.upd_valid = v;
        bus.upd_index = IW'(idx);
        bus.upd_tag   = TW'(tag);
        bus.upd_taken = tk;
    endtask

    task automatic single_update(input int idx, input int tag, input logic tk);
        clear_logs();
        drive_upd(1'b1, idx, tag, tk);
        step();
        drive_upd(1'b0, 0, 0, 1'b0);
        idle(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] exp_d;
        int            nxt;

        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        drive_upd(1'b0, 0, 0, 1'b0);
        bus.fetch_read_en   = 1'b0;
        bus.fetch_read_addr = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_upd_ready", 32'(bus.upd_ready), 1);
        chk("rst_write_en",  32'(bus.ram_write_en), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_read_en0",  32'(bus.ram_read_en), 0);
        bus.fetch_read_en   = 1'b1;
        bus.fetch_read_addr = 9'd3;
        #1;
        chk("rst_read_en1",  32'(bus.ram_read_en), 1);
        chk("rst_read_addr", 32'(bus.ram_read_addr), 3);
        bus.fetch_read_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss
        preload(5, '0);
        single_update(5, 'h0AB, 1'b1);
        chk("cold_pushes",   32'(push_cyc_q.size()), 1);
        chk("cold_reads",    32'(rd_addr_q.size()), 1);
        chk("cold_rd_addr",  32'(rd_addr_q[0]), 5);
        chk("cold_rd_lat",   32'(rd_cyc_q[0] - push_cyc_q[0]), 1);
        chk("cold_writes",   32'(wr_addr_q.size()), 1);
        chk("cold_wr_addr",  32'(wr_addr_q[0]), 5);
        chk("cold_wr_data",  32'(wr_data_q[0]), 32'({1'b1, 12'h0AB, 2'b10}));
        chk("cold_wr_lat",   32'(wr_cyc_q[0] - push_cyc_q[0]), 2);

        // Forwarding accumulation on one index
        preload(7, {1'b1, 12'h011, 2'b00});
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            drive_upd(1'b1, 7, 'h011, 1'b1);
            step();
        end
        drive_upd(1'b0, 0, 0, 1'b0);
        idle(4);
        chk("acc_writes", 32'(wr_addr_q.size()), 4);
        chk("acc_lat",    32'(wr_cyc_q[0] - push_cyc_q[0]), 2);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ec;
            ec = (i == 0) ? 2'b01 : (i == 1) ? 2'b10 : 2'b11;
            chk($sformatf("acc_data%0d", i), 32'(wr_data_q[i]), 32'({1'b1, 12'h011, ec}));
            chk($sformatf("acc_cyc%0d", i),  32'(wr_cyc_q[i] - wr_cyc_q[0]), 32'(i));
        end

        // Tag mismatch replaces entry
        preload(9, {1'b1, 12'h022, 2'b11});
        single_update(9, 'h033, 1'b0);
        chk("tag_writes", 32'(wr_addr_q.size()), 1);
        chk("tag_wr_data", 32'(wr_data_q[0]), 32'({1'b1, 12'h033, 2'b01}));

        // Saturation at zero
        preload(12, {1'b1, 12'h001, 2'b00});
        single_update(12, 'h001, 1'b0);
        chk("sat_wr_addr", 32'(wr_addr_q[0]), 12);
        chk("sat_wr_data", 32'(wr_data_q[0]), 32'({1'b1, 12'h001, 2'b00}));

        // Fetch priority with buffer filling
        for (int i = 20; i < 24; i++) preload(i, '0);
        clear_logs();
        bus.fetch_read_en   = 1'b1;
        bus.fetch_read_addr = 9'h1F0;
        nxt = 20;
        for (int k = 0; k < 8; k++) begin
            drive_upd(1'b1, nxt, 256 + nxt, nxt[0]);
            step();
            nxt = 20 + push_cyc_q.size();
        end
        chk("full_reads", 32'(rd_addr_q.size()), 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("full_rd_addr%0d", k), 32'(rd_addr_q[k]), 'h1F0);
        chk("full_accepted", 32'(push_cyc_q.size()), 4);
        chk("full_ready0",   32'(bus.upd_ready), 0);
        bus.fetch_read_en = 1'b0;
        drive_upd(1'b0, 0, 0, 1'b0);
        #1;
        chk("full_ready_pop", 32'(bus.upd_ready), 0);
        step();
        chk("full_ready_after", 32'(bus.upd_ready), 1);
        idle(4);
        chk("full_writes", 32'(wr_addr_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            exp_d = {1'b1, TW'(276 + i), ((i % 2) == 1) ? 2'b10 : 2'b01};
            chk($sformatf("full_wr_addr%0d", i), 32'(wr_addr_q[i]), 32'(20 + i));
            chk($sformatf("full_wr_data%0d", i), 32'(wr_data_q[i]), 32'(exp_d));
            chk($sformatf("full_wr_cyc%0d", i),  32'(wr_cyc_q[i] - wr_cyc_q[0]), 32'(i));
        end

        // Asynchronous reset with three buffered and one in stage M
        for (int i = 30; i < 34; i++) preload(i, '0);
        clear_logs();
        bus.fetch_read_en   = 1'b1;
        bus.fetch_read_addr = 9'h040;
        for (int i = 30; i < 34; i++) begin
            drive_upd(1'b1, i, i, 1'b1);
            step();
        end
        drive_upd(1'b0, 0, 0, 1'b0);
        bus.fetch_read_en = 1'b0;
        step();
        bus.fetch_read_en = 1'b1;
        #1;
        chk("ar_pre_write_en", 32'(bus.ram_write_en), 1);
        chk("ar_pre_busy",     32'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_write_en",  32'(bus.ram_write_en), 0);
        chk("ar_busy",      32'(bus.busy), 0);
        chk("ar_upd_ready", 32'(bus.upd_ready), 1);
        chk("ar_read_en",   32'(bus.ram_read_en), 1);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        bus.fetch_read_en = 1'b0;
        clear_logs();
        idle(4);
        chk("ar_no_writes",  32'(wr_addr_q.size()), 0);
        chk("ar_no_reads",   32'(rd_addr_q.size()), 0);
        chk("ar_busy_after", 32'(bus.busy), 0);
        chk("ar_ready_after", 32'(bus.upd_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
